// File: rtl/node_injector_if.sv
// Local request handshake, pass-through busy flags and injection output bus of the ring node.
interface node_injector_if #(
    parameter int unsigned ADDR_W     = 3,
    parameter int unsigned FIFO_DEPTH = 4
);
    localparam int unsigned PAYLOAD_W = 32 - 2 * ADDR_W;
    localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH) + 1;

    logic                 req_valid;
    logic                 req_ready;
    logic [ADDR_W-1:0]    req_dest;
    logic [PAYLOAD_W-1:0] req_payload;
    logic                 busy_cw;
    logic                 busy_ccw;
    logic [31:0]          instruction_out;
    logic                 controller_enable_out;
    logic [1:0]           enable;
    logic                 starve;
    logic [CNT_W-1:0]     fifo_count;
    logic [15:0]          sent_count;

    // Request source and controller side
    modport master (
        output req_valid, req_dest, req_payload, busy_cw, busy_ccw,
        input  req_ready, instruction_out, controller_enable_out, enable,
               starve, fifo_count, sent_count
    );

    // Injector side
    modport slave (
        input  req_valid, req_dest, req_payload, busy_cw, busy_ccw,
        output req_ready, instruction_out, controller_enable_out, enable,
               starve, fifo_count, sent_count
    );
endinterface

// File: rtl/node_injector.sv
// Ring node transmit side: buffers local requests in order and injects each one
// on its shortest-direction ring port when pass-through traffic leaves it free.
module node_injector #(
    parameter int unsigned                NODE_IP_BITWIDTH = 3,
    parameter logic [NODE_IP_BITWIDTH-1:0] NODE_IP          = '0,
    parameter logic [NODE_IP_BITWIDTH-1:0] MIDPOINT_NODE    = NODE_IP_BITWIDTH'(3),
    parameter int unsigned                FIFO_DEPTH       = 4,
    parameter int unsigned                STARVE_LIMIT     = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    node_injector_if.slave bus
);
    localparam int unsigned ADDR_W    = NODE_IP_BITWIDTH;
    localparam int unsigned PAYLOAD_W = 32 - 2 * ADDR_W;
    localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W     = PTR_W + 1;
    localparam int unsigned STARVE_W  = $clog2(STARVE_LIMIT + 1);

    localparam logic [1:0] DIR_CCW   = 2'b00;
    localparam logic [1:0] DIR_LOCAL = 2'b01;
    localparam logic [1:0] DIR_CW    = 2'b10;

    logic [ADDR_W-1:0]    r_mem_dest    [FIFO_DEPTH];
    logic [PAYLOAD_W-1:0] r_mem_payload [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_count;
    logic [31:0]          r_instr;
    logic [1:0]           r_enable;
    logic                 r_ctrl_en;
    logic [15:0]          r_sent;
    logic [STARVE_W-1:0]  r_starve_cnt;
    logic                 r_starve;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_issue;
    logic [ADDR_W-1:0]    w_head_dest;
    logic [PAYLOAD_W-1:0] w_head_payload;
    logic [ADDR_W-1:0]    w_dist;
    logic [1:0]           w_dir;
    logic                 w_port_free;

    assign w_full         = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_empty        = (r_count == '0);
    assign w_push         = bus.req_valid & ~w_full;
    assign w_head_dest    = r_mem_dest[r_rd_ptr];
    assign w_head_payload = r_mem_payload[r_rd_ptr];
    assign w_dist         = w_head_dest - NODE_IP;

    // Shortest ring direction for the head; the half-ring tie goes counter-clockwise
    always_comb begin
        w_dir       = DIR_CCW;
        w_port_free = ~bus.busy_ccw;
        if (w_dist == '0) begin
            w_dir       = DIR_LOCAL;
            w_port_free = 1'b1;
        end else if (w_dist <= MIDPOINT_NODE) begin
            w_dir       = DIR_CW;
            w_port_free = ~bus.busy_cw;
        end
    end

    assign w_issue = ~w_empty & w_port_free;

    // Request storage and write pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                r_mem_dest[i]    <= '0;
                r_mem_payload[i] <= '0;
            end
            r_wr_ptr <= '0;
        end else if (w_push) begin
            r_mem_dest[r_wr_ptr]    <= bus.req_dest;
            r_mem_payload[r_wr_ptr] <= bus.req_payload;
            r_wr_ptr                <= r_wr_ptr + PTR_W'(1);
        end
    end

    // Read pointer and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_issue})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Injection output: instruction and port hold between issues, strobe is one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr   <= '0;
            r_enable  <= DIR_CCW;
            r_ctrl_en <= 1'b0;
            r_sent    <= '0;
        end else if (w_issue) begin
            r_instr   <= {w_head_dest, NODE_IP, w_head_payload};
            r_enable  <= w_dir;
            r_ctrl_en <= 1'b1;
            r_sent    <= r_sent + 16'(1);
        end else begin
            r_ctrl_en <= 1'b0;
        end
    end

    // Starvation tracking; the flag follows the counter one edge later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= '0;
            r_starve     <= 1'b0;
        end else begin
            if (w_empty || w_issue) begin
                r_starve_cnt <= '0;
            end else if (r_starve_cnt != STARVE_W'(STARVE_LIMIT)) begin
                r_starve_cnt <= r_starve_cnt + STARVE_W'(1);
            end
            r_starve <= (r_starve_cnt == STARVE_W'(STARVE_LIMIT));
        end
    end

    assign bus.req_ready             = ~w_full;
    assign bus.instruction_out       = r_instr;
    assign bus.enable                = r_enable;
    assign bus.controller_enable_out = r_ctrl_en;
    assign bus.sent_count            = r_sent;
    assign bus.fifo_count            = r_count;
    assign bus.starve                = r_starve;
endmodule

// File: tb/tb_node_injector.sv
// Scoreboard bench for node_injector with NODE_IP=2.
module tb_node_injector;
    logic clk;
    logic rst_n;

    int n_cmp = 0;
    int n_err = 0;

    logic [33:0] exp_q [$];

    node_injector_if #(.ADDR_W(3), .FIFO_DEPTH(4)) u_if ();

    node_injector #(
        .NODE_IP_BITWIDTH (3),
        .NODE_IP          (3'd2),
        .MIDPOINT_NODE    (3'd3),
        .FIFO_DEPTH       (4),
        .STARVE_LIMIT     (8)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every issued instruction must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n && u_if.controller_enable_out) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_issue: got en=%b instr=%h, required no issue",
                         u_if.enable, u_if.instruction_out);
            end else begin
                logic [33:0] e;
                e = exp_q.pop_front();
                if ({u_if.enable, u_if.instruction_out} !== e) begin
                    n_err++;
                    $display("FAIL issue_order: got en=%b instr=%h, required en=%b instr=%h",
                             u_if.enable, u_if.instruction_out, e[33:32], e[31:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One request, accepted on the next rising edge; inputs released #1 after it
    task automatic send(input logic [2:0] dest, input logic [25:0] pl,
                        input bit expect_issue, input logic [1:0] exp_en);
        u_if.req_valid   = 1'b1;
        u_if.req_dest    = dest;
        u_if.req_payload = pl;
        if (expect_issue) exp_q.push_back({exp_en, dest, 3'd2, pl});
        @(posedge clk);
        #1;
        u_if.req_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int cyc;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 200) begin
            @(posedge clk);
            cyc++;
        end
        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: got %0d pending, required 0", name, exp_q.size());
        end
    endtask

    logic [1:0] dir_lut [8];

    initial begin
        // hand-computed ports for NODE_IP=2, indexed by dest
        dir_lut = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00};
        u_if.req_valid   = 1'b0;
        u_if.req_dest    = '0;
        u_if.req_payload = '0;
        u_if.busy_cw     = 1'b0;
        u_if.busy_ccw    = 1'b0;

        // Reset mid-operation discards a buffered request
        do_reset();
        chk("reset_fifo_count", 32'(u_if.fifo_count), 32'd0);
        chk("reset_ready", 32'(u_if.req_ready), 32'd1);
        send(3'd2, 26'h0123456, 1'b1, 2'b01);
        wait_drain("pre_reset");
        u_if.busy_cw = 1'b1;
        send(3'd5, 26'h1111111, 1'b0, 2'b00);
        chk("pre_reset_count", 32'(u_if.fifo_count), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_instr", u_if.instruction_out, 32'd0);
        chk("rst_enable", 32'(u_if.enable), 32'd0);
        chk("rst_ctrl_en", 32'(u_if.controller_enable_out), 32'd0);
        chk("rst_fifo_count", 32'(u_if.fifo_count), 32'd0);
        chk("rst_sent", 32'(u_if.sent_count), 32'd0);
        chk("rst_starve", 32'(u_if.starve), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        u_if.busy_cw = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("post_rst_count", 32'(u_if.fifo_count), 32'd0);
        chk("post_rst_sent", 32'(u_if.sent_count), 32'd0);

        // Loopback ignores both busy flags, one-cycle latency
        do_reset();
        u_if.busy_cw  = 1'b1;
        u_if.busy_ccw = 1'b1;
        send(3'd2, 26'h0ABCDEF, 1'b1, 2'b01);
        chk("loop_not_early", 32'(u_if.controller_enable_out), 32'd0);
        @(posedge clk);
        #1;
        chk("loop_ctrl_en", 32'(u_if.controller_enable_out), 32'd1);
        chk("loop_enable", 32'(u_if.enable), 32'd1);
        chk("loop_instr", u_if.instruction_out, 32'h48ABCDEF);
        wait_drain("loop");
        u_if.busy_cw  = 1'b0;
        u_if.busy_ccw = 1'b0;

        // Direction sweep, including the half-ring tie (dest 6)
        do_reset();
        send(3'd3, 26'h0000001, 1'b1, 2'b10);
        send(3'd5, 26'h0000002, 1'b1, 2'b10);
        send(3'd6, 26'h0000003, 1'b1, 2'b00);
        send(3'd0, 26'h0000004, 1'b1, 2'b00);
        wait_drain("sweep");
        chk("sweep_sent", 32'(u_if.sent_count), 32'd4);

        // Starvation on a blocked clockwise head
        do_reset();
        u_if.busy_cw = 1'b1;
        send(3'd5, 26'h2222222, 1'b1, 2'b10);
        repeat (4) @(posedge clk);
        #1;
        chk("starve_early", 32'(u_if.starve), 32'd0);
        repeat (8) @(posedge clk);
        #1;
        chk("starve_high", 32'(u_if.starve), 32'd1);
        chk("starve_blocked", 32'(u_if.controller_enable_out), 32'd0);
        u_if.busy_cw = 1'b0;
        @(posedge clk);
        #1;
        chk("starve_issue", 32'(u_if.controller_enable_out), 32'd1);
        chk("starve_hold", 32'(u_if.starve), 32'd1);
        @(posedge clk);
        #1;
        chk("starve_clear", 32'(u_if.starve), 32'd0);
        wait_drain("starve");

        // Full FIFO behind a blocked head, no bypass
        do_reset();
        u_if.busy_ccw = 1'b1;
        send(3'd0, 26'h0000010, 1'b1, 2'b00);
        send(3'd3, 26'h0000011, 1'b1, 2'b10);
        send(3'd0, 26'h0000012, 1'b1, 2'b00);
        send(3'd0, 26'h0000013, 1'b1, 2'b00);
        chk("full_count", 32'(u_if.fifo_count), 32'd4);
        chk("full_ready", 32'(u_if.req_ready), 32'd0);
        send(3'd3, 26'h0000014, 1'b0, 2'b00);
        chk("full_reject", 32'(u_if.fifo_count), 32'd4);
        repeat (3) @(posedge clk);
        #1;
        chk("full_no_bypass", 32'(u_if.sent_count), 32'd0);
        u_if.busy_ccw = 1'b0;
        wait_drain("full");
        chk("full_sent", 32'(u_if.sent_count), 32'd4);
        chk("full_drained", 32'(u_if.fifo_count), 32'd0);

        // Continuous traffic: one push and one issue per cycle
        do_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (u_if.fifo_count > 1) begin
                n_cmp++;
                n_err++;
                $display("FAIL stream_occupancy: got %0d, required <=1", u_if.fifo_count);
            end
            u_if.req_valid   = 1'b1;
            u_if.req_dest    = 3'(i % 8);
            u_if.req_payload = 26'(i + 26'h100);
            exp_q.push_back({dir_lut[i % 8], 3'(i % 8), 3'd2, 26'(i + 26'h100)});
        end
        @(negedge clk);
        u_if.req_valid = 1'b0;
        wait_drain("stream");
        chk("stream_sent", 32'(u_if.sent_count), 32'd20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required finish");
        $fatal(1, "watchdog expired");
    end
endmodule
